crash_event_ctrl: RTL

- Sits directly downstream of game_ctrl and consumes its per-pixel crash flags (crash_enemy_bullet, crash_me_enemy) and game status.
- Collapses many pixel-level overlap pulses per frame into at most one event per frame.
- Runs the enemy explosion/respawn sequence and keeps a 4-digit BCD score, a lives counter and a player invulnerability window for the renderers and HUD.

---
 rtl/crash_event_ctrl_pkg.sv | 25 ++
 rtl/crash_event_ctrl_bcd_add_sat.sv | 37 +++
 rtl/crash_event_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/crash_event_ctrl_pkg.sv
// Shared definitions for crash_event_ctrl and the blocks around it.
// - Game status width and encodings. game_ctrl and this block use the same ones.
// - Score digit count and the saturated score ceiling.
// - Enemy sequencer state type.
package crash_event_ctrl_pkg;

  localparam int GAME_STATUS_BIT_LEN = 3;

  localparam logic [GAME_STATUS_BIT_LEN-1:0] GAME_STATUS_PAUSE  = 3'b000;
  localparam logic [GAME_STATUS_BIT_LEN-1:0] GAME_STATUS_RUN    = 3'b001;
  localparam logic [GAME_STATUS_BIT_LEN-1:0] GAME_STATUS_PRERUN = 3'b010;
  localparam logic [GAME_STATUS_BIT_LEN-1:0] GAME_STATUS_OVER   = 3'b011;

  localparam int SCORE_DIGITS = 4;
  localparam int SCORE_W      = 4 * SCORE_DIGITS;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

  typedef enum logic [1:0] {
    ENEMY_ALIVE   = 2'd0,
    ENEMY_EXPLODE = 2'd1,
    ENEMY_RESPAWN = 2'd2
  } enemy_state_t;

endpackage

// File: rtl/crash_event_ctrl_bcd_add_sat.sv
// bcd_add_sat: a combinational BCD adder with saturation.
// - Adds a single BCD digit to a packed BCD number that has SCORE_DIGITS digits.
// - If the result overflows the top digit, the output is clamped to all nines. It never wraps.
// Ports:
//   a       in   packed BCD operand, most significant digit in the top nibble
//   addend  in   single BCD digit, 0..9
//   sum     out  saturated BCD sum
module bcd_add_sat
  import crash_event_ctrl_pkg::*;
(
  input  logic [SCORE_W-1:0] a,
  input  logic [3:0]         addend,
  output logic [SCORE_W-1:0] sum
);

  logic [SCORE_DIGITS:0] carry;
  logic [4:0]            digit_sum [SCORE_DIGITS];
  logic [SCORE_W-1:0]    raw;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_digit
      // Only the lowest digit receives the addend. The digits above it take the ripple carry.
      // The largest digit sum is 9+9 = 18, so 5 bits are enough.
      assign digit_sum[gi] = {1'b0, a[4*gi +: 4]}
                           + {1'b0, ((gi == 0) ? addend : 4'd0)}
                           + {4'd0, carry[gi]};
      assign carry[gi+1]   = (digit_sum[gi] > 5'd9);
      assign raw[4*gi +: 4] = carry[gi+1] ? 4'(digit_sum[gi] - 5'd10)
                                          : digit_sum[gi][3:0];
    end
  endgenerate

  assign sum = carry[SCORE_DIGITS] ? SCORE_MAX : raw;

endmodule

// File: rtl/crash_event_ctrl.sv
// crash_event_ctrl: frame-level crash event controller. It sits after game_ctrl.
// - Collapses the per-pixel crash pulses into at most one event of each kind per frame.
// - Runs the enemy explosion/respawn sequence.
// - Keeps the BCD score, the lives counter and the player invulnerability window.
// Ports:
//   clk_vga               pixel clock
//   rst                   asynchronous active-high reset
//   frame_end_i           one-cycle pulse at the end of each frame's visible area
//   game_status_i         PAUSE / RUN / PRERUN / OVER
//   crash_enemy_bullet_i  per-pixel enemy/bullet overlap
//   crash_me_enemy_i      per-pixel player/enemy overlap
//   enemy_hit_o           pulse: an enemy kill was registered
//   me_hit_o              pulse: the player lost a life
//   respawn_o             pulse: the enemy may be respawned
//   explode_active_o      the explosion animation is running
//   explode_step_o        explosion sprite index 0..3
//   invuln_o              the player is invulnerable
//   score_o               4-digit BCD score
//   lives_o               remaining lives
//   dead_o                lives exhausted (sticky)
module crash_event_ctrl
  import crash_event_ctrl_pkg::*;
#(
  parameter int SCORE_INC     = 1,
  parameter int LIVES_INIT    = 3,
  parameter int EXPLODE_HOLD  = 4,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                           clk_vga,
  input  logic                           rst,
  input  logic                           frame_end_i,
  input  logic [GAME_STATUS_BIT_LEN-1:0] game_status_i,
  input  logic                           crash_enemy_bullet_i,
  input  logic                           crash_me_enemy_i,
  output logic                           enemy_hit_o,
  output logic                           me_hit_o,
  output logic                           respawn_o,
  output logic                           explode_active_o,
  output logic [1:0]                     explode_step_o,
  output logic                           invuln_o,
  output logic [SCORE_W-1:0]             score_o,
  output logic [1:0]                     lives_o,
  output logic                           dead_o
);

  localparam logic [3:0] HOLD_LAST   = 4'(EXPLODE_HOLD - 1);
  localparam logic [1:0] LIVES_START = 2'(LIVES_INIT);
  localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES);

  enemy_state_t                   state_reg, state_next;
  logic [1:0]                     step_reg, step_next;
  logic [3:0]                     hold_reg, hold_next;
  logic [SCORE_W-1:0]             score_reg, score_next, score_inc_sum;
  logic [1:0]                     lives_reg, lives_next;
  logic [7:0]                     invuln_reg, invuln_next;
  logic                           dead_reg, dead_next;
  logic                           enemy_hit_reg, enemy_hit_next;
  logic                           me_hit_reg, me_hit_next;
  logic                           eb_f_reg, eb_f_next;
  logic                           me_f_reg, me_f_next;
  logic [GAME_STATUS_BIT_LEN-1:0] status_prev_reg;

  logic is_run, tick, eb, me, prerun_entry;

  assign is_run       = (game_status_i == GAME_STATUS_RUN);
  assign tick         = frame_end_i && is_run;
  // A crash in the frame_end cycle itself still counts for the frame that is ending.
  assign eb           = eb_f_reg | crash_enemy_bullet_i;
  assign me           = me_f_reg | crash_me_enemy_i;
  assign prerun_entry = (game_status_i == GAME_STATUS_PRERUN) &&
                        (status_prev_reg != GAME_STATUS_PRERUN);

  bcd_add_sat u_score_add (
    .a      (score_reg),
    .addend (4'(SCORE_INC)),
    .sum    (score_inc_sum)
  );

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_reg       <= ENEMY_ALIVE;
      step_reg        <= 2'd0;
      hold_reg        <= 4'd0;
      score_reg       <= '0;
      lives_reg       <= LIVES_START;
      invuln_reg      <= 8'd0;
      dead_reg        <= 1'b0;
      enemy_hit_reg   <= 1'b0;
      me_hit_reg      <= 1'b0;
      eb_f_reg        <= 1'b0;
      me_f_reg        <= 1'b0;
      status_prev_reg <= GAME_STATUS_PAUSE;
    end else begin
      state_reg       <= state_next;
      step_reg        <= step_next;
      hold_reg        <= hold_next;
      score_reg       <= score_next;
      lives_reg       <= lives_next;
      invuln_reg      <= invuln_next;
      dead_reg        <= dead_next;
      enemy_hit_reg   <= enemy_hit_next;
      me_hit_reg      <= me_hit_next;
      eb_f_reg        <= eb_f_next;
      me_f_reg        <= me_f_next;
      status_prev_reg <= game_status_i;
    end
  end

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    hold_next      = hold_reg;
    score_next     = score_reg;
    lives_next     = lives_reg;
    invuln_next    = invuln_reg;
    dead_next      = dead_reg;
    enemy_hit_next = 1'b0;
    me_hit_next    = 1'b0;
    eb_f_next      = eb_f_reg;
    me_f_next      = me_f_reg;

    // The flags accumulate over the frame and restart after every frame_end.
    if (frame_end_i) begin
      eb_f_next = 1'b0;
      me_f_next = 1'b0;
    end else begin
      if (crash_enemy_bullet_i && is_run) eb_f_next = 1'b1;
      if (crash_me_enemy_i && is_run)     me_f_next = 1'b1;
    end

    case (state_reg)
      ENEMY_ALIVE: begin
        if (tick && eb) begin
          enemy_hit_next = 1'b1;
          score_next     = score_inc_sum;
          state_next     = ENEMY_EXPLODE;
          step_next      = 2'd0;
          hold_next      = 4'd0;
        end
      end
      ENEMY_EXPLODE: begin
        if (tick) begin
          if (hold_reg == HOLD_LAST) begin
            hold_next = 4'd0;
            if (step_reg == 2'd3) begin
              state_next = ENEMY_RESPAWN;
              step_next  = 2'd0;
            end else begin
              step_next = step_reg + 2'd1;
            end
          end else begin
            hold_next = hold_reg + 4'd1;
          end
        end
      end
      ENEMY_RESPAWN: state_next = ENEMY_ALIVE;
      default:       state_next = ENEMY_ALIVE;
    endcase

    if (tick) begin
      if (me && (invuln_reg == 8'd0) && (lives_reg != 2'd0)) begin
        lives_next  = lives_reg - 2'd1;
        me_hit_next = 1'b1;
        invuln_next = INVULN_LOAD;
        if (lives_reg == 2'd1) dead_next = 1'b1;
      end else if (invuln_reg != 8'd0) begin
        invuln_next = invuln_reg - 8'd1;
      end
    end

    // On entry to PRERUN, re-initialise synchronously to the reset state.
    if (prerun_entry) begin
      state_next     = ENEMY_ALIVE;
      step_next      = 2'd0;
      hold_next      = 4'd0;
      score_next     = '0;
      lives_next     = LIVES_START;
      invuln_next    = 8'd0;
      dead_next      = 1'b0;
      enemy_hit_next = 1'b0;
      me_hit_next    = 1'b0;
      eb_f_next      = 1'b0;
      me_f_next      = 1'b0;
    end
  end

  assign enemy_hit_o      = enemy_hit_reg;
  assign me_hit_o         = me_hit_reg;
  assign respawn_o        = (state_reg == ENEMY_RESPAWN);
  assign explode_active_o = (state_reg == ENEMY_EXPLODE);
  assign explode_step_o   = step_reg;
  assign invuln_o         = (invuln_reg != 8'd0);
  assign score_o          = score_reg;
  assign lives_o          = lives_reg;
  assign dead_o           = dead_reg;

endmodule
